// File: rtl/riscv_pkg.sv
// Shared encodings and pipeline-register payloads for the RISC-V pipeline.
// Covers data-memory access control, write-back source and the EX/MEM and MEM/WB bundles.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  localparam logic [2:0] DM_BYTE   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_WORD   = 3'b010;
  localparam logic [2:0] DM_BYTE_U = 3'b100;
  localparam logic [2:0] DM_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_NONE = 2'b11
  } wb_src_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } acc_size_e;

  // Unlisted DMCtrl encodings fall back to a word access.
  function automatic acc_size_e dm_size(input logic [2:0] ctrl);
    case (ctrl)
      DM_BYTE, DM_BYTE_U: dm_size = SZ_BYTE;
      DM_HALF, DM_HALF_U: dm_size = SZ_HALF;
      default:            dm_size = SZ_WORD;
    endcase
  endfunction

  typedef struct packed {
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] ru2;
    logic [XLEN-1:0] pc;
    logic [REGW-1:0] rd;
    logic            ru_wr;
    logic            dm_wr;
    logic [2:0]      dm_ctrl;
    wb_src_e         wb_src;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [REGW-1:0] rd;
    logic            ru_wr;
  } mem_wb_t;

endpackage

// File: rtl/data_mem.sv
// Word-organised data memory with per-byte write enables.
// Synchronous write, combinational read, contents never reset.
module data_mem #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               be,
  input  logic                     we,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM and MEM/WB registers, sized load/store
// against the local data memory, and the write-back source select.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  alu_out_ex,
  input  logic [XLEN-1:0]  ru2_fwd_ex,
  input  logic [XLEN-1:0]  pc_ex,
  input  logic [REGW-1:0]  rd_ex,
  input  logic             RuWr_ex,
  input  logic             DMWr_ex,
  input  logic [2:0]       DMCtrl_ex,
  input  logic [1:0]       RuDataWrSrc_ex,
  input  logic             flush_ex,
  output logic [XLEN-1:0]  alu_out_me,
  output logic [REGW-1:0]  rd_me,
  output logic             RuWr_me,
  output logic [XLEN-1:0]  muxData,
  output logic [REGW-1:0]  rd_wb,
  output logic             RuWr_wb,
  output logic             misaligned_me
);

  localparam int unsigned AW = $clog2(DEPTH);

  ex_mem_t   ex_mem_d, ex_mem_q;
  mem_wb_t   mem_wb_d, mem_wb_q;
  acc_size_e size_me;
  logic [1:0]  boff;
  logic        is_load, is_store, mis_raw, dm_we, sext;
  logic [3:0]  st_be;
  logic [31:0] st_data, rd_word, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // A flushed instruction keeps its payload but loses both write enables.
  always_comb begin
    ex_mem_d         = '0;
    ex_mem_d.alu_out = alu_out_ex;
    ex_mem_d.ru2     = ru2_fwd_ex;
    ex_mem_d.pc      = pc_ex;
    ex_mem_d.rd      = rd_ex;
    ex_mem_d.ru_wr   = RuWr_ex & ~flush_ex;
    ex_mem_d.dm_wr   = DMWr_ex & ~flush_ex;
    ex_mem_d.dm_ctrl = DMCtrl_ex;
    ex_mem_d.wb_src  = wb_src_e'(RuDataWrSrc_ex);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_mem_q <= '0;
    else        ex_mem_q <= ex_mem_d;
  end

  assign size_me  = dm_size(ex_mem_q.dm_ctrl);
  assign boff     = ex_mem_q.alu_out[1:0];
  assign is_load  = (ex_mem_q.wb_src == WB_MEM);
  assign is_store = ex_mem_q.dm_wr;
  assign sext     = ~ex_mem_q.dm_ctrl[2];

  // Alignment check plus store lane/data steering.
  always_comb begin
    mis_raw = 1'b0;
    st_be   = 4'b1111;
    st_data = ex_mem_q.ru2;
    case (size_me)
      SZ_BYTE: begin
        st_be   = 4'(4'b0001 << boff);
        st_data = {4{ex_mem_q.ru2[7:0]}};
      end
      SZ_HALF: begin
        mis_raw = boff[0];
        st_be   = boff[1] ? 4'b1100 : 4'b0011;
        st_data = {2{ex_mem_q.ru2[15:0]}};
      end
      default: mis_raw = |boff;
    endcase
  end

  assign misaligned_me = (is_load | is_store) & mis_raw;
  assign dm_we         = is_store & ~mis_raw;

  data_mem #(.DEPTH(DEPTH)) u_dmem (
    .clk   (clk),
    .addr  (ex_mem_q.alu_out[AW+1:2]),
    .wdata (st_data),
    .be    (st_be),
    .we    (dm_we),
    .rdata (rd_word)
  );

  assign ld_byte = rd_word[{boff, 3'b000} +: 8];
  assign ld_half = rd_word[{boff[1], 4'b0000} +: 16];

  // Lane extraction and extension; a misaligned load returns zero.
  always_comb begin
    ld_data = rd_word;
    case (size_me)
      SZ_BYTE: ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{sext & ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
    if (mis_raw) ld_data = '0;
  end

  // Write-back select; a misaligned load also drops its register write.
  always_comb begin
    mem_wb_d       = '0;
    mem_wb_d.rd    = ex_mem_q.rd;
    mem_wb_d.ru_wr = ex_mem_q.ru_wr;
    case (ex_mem_q.wb_src)
      WB_ALU:  mem_wb_d.data = ex_mem_q.alu_out;
      WB_MEM:  mem_wb_d.data = ld_data;
      WB_PC4:  mem_wb_d.data = ex_mem_q.pc + 32'd4;
      default: mem_wb_d.data = '0;
    endcase
    if (is_load && mis_raw) begin
      mem_wb_d.rd    = '0;
      mem_wb_d.ru_wr = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_wb_q <= '0;
    else        mem_wb_q <= mem_wb_d;
  end

  assign alu_out_me = ex_mem_q.alu_out;
  assign rd_me      = ex_mem_q.rd;
  assign RuWr_me    = ex_mem_q.ru_wr;
  assign muxData    = mem_wb_q.data;
  assign rd_wb      = mem_wb_q.rd;
  assign RuWr_wb    = mem_wb_q.ru_wr;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// back-to-back stream scored against a byte-array memory model.
module tb_mem_stage;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned NBYTES = 4 * DEPTH;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] ru2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        ruwr;
    logic        dmwr;
    logic [2:0]  ctrl;
    logic [1:0]  src;
    logic        flush;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_out_ex, ru2_fwd_ex, pc_ex;
  logic [4:0]  rd_ex;
  logic        RuWr_ex, DMWr_ex, flush_ex;
  logic [2:0]  DMCtrl_ex;
  logic [1:0]  RuDataWrSrc_ex;
  logic [31:0] alu_out_me, muxData;
  logic [4:0]  rd_me, rd_wb;
  logic        RuWr_me, RuWr_wb, misaligned_me;

  int errors = 0;
  int checks = 0;
  logic [7:0] mm [NBYTES];

  mem_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_out_ex(alu_out_ex), .ru2_fwd_ex(ru2_fwd_ex), .pc_ex(pc_ex),
    .rd_ex(rd_ex), .RuWr_ex(RuWr_ex), .DMWr_ex(DMWr_ex), .DMCtrl_ex(DMCtrl_ex),
    .RuDataWrSrc_ex(RuDataWrSrc_ex), .flush_ex(flush_ex),
    .alu_out_me(alu_out_me), .rd_me(rd_me), .RuWr_me(RuWr_me),
    .muxData(muxData), .rd_wb(rd_wb), .RuWr_wb(RuWr_wb),
    .misaligned_me(misaligned_me)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] ru2,
                                input logic [31:0] pc, input logic [4:0] rd,
                                input logic ruwr, input logic dmwr, input logic [2:0] ctrl,
                                input logic [1:0] src, input logic flush);
    mk = '{alu, ru2, pc, rd, ruwr, dmwr, ctrl, src, flush};
  endfunction

  function automatic instr_t ld(input logic [31:0] a, input logic [2:0] c, input logic [4:0] r);
    ld = mk(a, 32'h0, 32'h0, r, 1'b1, 1'b0, c, 2'b01, 1'b0);
  endfunction

  function automatic instr_t st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    st = mk(a, d, 32'h0, 5'd0, 1'b0, 1'b1, c, 2'b00, 1'b0);
  endfunction

  task automatic drive(input instr_t in);
    alu_out_ex = in.alu;  ru2_fwd_ex = in.ru2; pc_ex = in.pc; rd_ex = in.rd;
    RuWr_ex = in.ruwr;    DMWr_ex = in.dmwr;   DMCtrl_ex = in.ctrl;
    RuDataWrSrc_ex = in.src; flush_ex = in.flush;
  endtask

  // Runs one instruction alone through MEM and WB, returning what was observed.
  task automatic exec_one(input instr_t in, output logic [31:0] o_alu, output logic [4:0] o_rd,
                          output logic o_wr, output logic o_mis, output logic [31:0] o_data,
                          output logic [4:0] o_rdwb, output logic o_wrwb);
    @(negedge clk); drive(in);
    @(posedge clk); #1;
    o_alu = alu_out_me; o_rd = rd_me; o_wr = RuWr_me; o_mis = misaligned_me;
    @(negedge clk); drive('0);
    @(posedge clk); #1;
    o_data = muxData; o_rdwb = rd_wb; o_wrwb = RuWr_wb;
  endtask

  // Behavioural model: byte-addressed memory, access size in bytes, sign by encoding.
  task automatic model(input instr_t in, output logic [31:0] d, output logic [4:0] rd,
                       output logic wr, output logic mis);
    int unsigned a, sz;
    logic is_ld, is_st;
    logic [31:0] v;
    a     = in.alu % NBYTES;
    sz    = (in.ctrl == 3'd0 || in.ctrl == 3'd4) ? 1 : (in.ctrl == 3'd1 || in.ctrl == 3'd5) ? 2 : 4;
    is_ld = (in.src == 2'b01);
    is_st = in.dmwr && !in.flush;
    mis   = (is_ld || is_st) && (a % sz != 0);
    v = 32'h0;
    if (!mis) for (int i = 0; i < int'(sz); i++) v = v | (32'(mm[a + i]) << (8 * i));
    if (!in.ctrl[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    if (is_st && !mis) for (int i = 0; i < int'(sz); i++) mm[a + i] = in.ru2[8*i +: 8];
    case (in.src)
      2'b00:   d = in.alu;
      2'b01:   d = mis ? 32'h0 : v;
      2'b10:   d = in.pc + 32'd4;
      default: d = 32'h0;
    endcase
    wr = in.ruwr && !in.flush && !(is_ld && mis);
    rd = (is_ld && mis) ? 5'd0 : in.rd;
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    int unsigned kind;
    kind = $urandom_range(0, 9);
    r = mk($urandom, $urandom, $urandom, 5'($urandom), 1'b1, 1'b0,
           3'($urandom_range(0, 7)), 2'b00, ($urandom_range(0, 7) == 0));
    if (kind >= 3 && kind <= 8) r.alu = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
    if (kind >= 3 && kind <= 5) r.src = 2'b01;
    if (kind >= 6 && kind <= 8) begin r.dmwr = 1'b1; r.ruwr = 1'b0; end
    if (kind == 9) r.src = 2'($urandom_range(2, 3));
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; drive('0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (alu_out_me !== 32'h0) begin errors++; $display("FAIL reset_alu_me: got %h want 0", alu_out_me); end
    checks++; if (rd_me !== 5'd0 || RuWr_me !== 1'b0) begin errors++; $display("FAIL reset_me: rd=%0d wr=%b want 0", rd_me, RuWr_me); end
    checks++; if (muxData !== 32'h0) begin errors++; $display("FAIL reset_muxData: got %h want 0", muxData); end
    checks++; if (rd_wb !== 5'd0 || RuWr_wb !== 1'b0 || misaligned_me !== 1'b0) begin
      errors++; $display("FAIL reset_wb: rd=%0d wr=%b mis=%b want 0", rd_wb, RuWr_wb, misaligned_me); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] a, d; logic [4:0] r, rw; logic w, m, ww;
    exec_one(st(32'h10, 32'hDEAD_BEEF, 3'b010), a, r, w, m, d, rw, ww);
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL sw_aligned_mis: got %b want 0", m); end
    exec_one(ld(32'h10, 3'b010, 5'd5), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", d); end
    checks++; if (ww !== 1'b1 || rw !== 5'd5) begin errors++; $display("FAIL lw_wb: wr=%b rd=%0d want 1/5", ww, rw); end
  endtask

  task automatic test_byte_half();
    logic [31:0] a, d; logic [4:0] r, rw; logic w, m, ww;
    exec_one(ld(32'h13, 3'b000, 5'd6), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'hFFFF_FFDE) begin errors++; $display("FAIL lb: got %h want ffffffde", d); end
    exec_one(ld(32'h13, 3'b100, 5'd6), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'h0000_00DE) begin errors++; $display("FAIL lbu: got %h want 000000de", d); end
    exec_one(ld(32'h12, 3'b001, 5'd6), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'hFFFF_DEAD) begin errors++; $display("FAIL lh: got %h want ffffdead", d); end
    exec_one(ld(32'h10, 3'b101, 5'd6), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu: got %h want 0000beef", d); end
    exec_one(ld(32'h10, 3'b111, 5'd6), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ctrl111_word: got %h want deadbeef", d); end
  endtask

  task automatic test_sb_and_misaligned();
    logic [31:0] a, d; logic [4:0] r, rw; logic w, m, ww;
    exec_one(st(32'h11, 32'h1234_56AA, 3'b000), a, r, w, m, d, rw, ww);
    exec_one(ld(32'h10, 3'b010, 5'd7), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'hDEAD_AAEF) begin errors++; $display("FAIL sb_merge: got %h want deadaaef", d); end
    exec_one(st(32'h12, 32'h1111_1111, 3'b010), a, r, w, m, d, rw, ww);
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL sw_mis_flag: got %b want 1", m); end
    exec_one(ld(32'h10, 3'b010, 5'd7), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'hDEAD_AAEF) begin errors++; $display("FAIL sw_mis_nowrite: got %h want deadaaef", d); end
    exec_one(ld(32'h11, 3'b001, 5'd8), a, r, w, m, d, rw, ww);
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL lh_mis_flag: got %b want 1", m); end
    checks++; if (ww !== 1'b0 || d !== 32'h0 || rw !== 5'd0) begin
      errors++; $display("FAIL lh_mis_wb: wr=%b data=%h rd=%0d want 0/0/0", ww, d, rw); end
    exec_one(mk(32'h13, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 3'b010, 2'b00, 1'b0), a, r, w, m, d, rw, ww);
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL alu_no_mis: got %b want 0", m); end
  endtask

  task automatic test_jal_flush();
    logic [31:0] a, d; logic [4:0] r, rw; logic w, m, ww;
    exec_one(mk(32'h0, 32'h0, 32'h100, 5'd1, 1'b1, 1'b0, 3'b000, 2'b10, 1'b0), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'h104 || rw !== 5'd1 || ww !== 1'b1) begin
      errors++; $display("FAIL jal: data=%h rd=%0d wr=%b want 104/1/1", d, rw, ww); end
    exec_one(mk(32'h0, 32'h0, 32'h100, 5'd1, 1'b1, 1'b0, 3'b000, 2'b10, 1'b1), a, r, w, m, d, rw, ww);
    checks++; if (w !== 1'b0 || ww !== 1'b0) begin errors++; $display("FAIL jal_flush: me=%b wb=%b want 0/0", w, ww); end
    exec_one(mk(32'h0, 32'h0, 32'hFFFF_FFFC, 5'd1, 1'b1, 1'b0, 3'b000, 2'b10, 1'b0), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL pc4_wrap: got %h want 0", d); end
    exec_one(mk(32'h10, 32'h5555_5555, 32'h0, 5'd0, 1'b0, 1'b1, 3'b010, 2'b00, 1'b1), a, r, w, m, d, rw, ww);
    exec_one(ld(32'h10, 3'b010, 5'd0), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'hDEAD_AAEF || rw !== 5'd0) begin
      errors++; $display("FAIL flushed_store: data=%h rd=%0d want deadaaef/0", d, rw); end
  endtask

  task automatic test_forward();
    logic [31:0] a, d; logic [4:0] r, rw; logic w, m, ww;
    exec_one(mk(32'h55, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0), a, r, w, m, d, rw, ww);
    checks++; if (a !== 32'h55 || w !== 1'b1 || r !== 5'd9) begin
      errors++; $display("FAIL fwd_me: alu=%h wr=%b rd=%0d want 55/1/9", a, w, r); end
    checks++; if (d !== 32'h55) begin errors++; $display("FAIL alu_wb: got %h want 55", d); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive(st(32'h20, 32'hCAFE_F00D, 3'b010));
    @(negedge clk); drive(ld(32'h20, 3'b010, 5'd4));
    @(negedge clk); drive('0);
    @(posedge clk); #1;
    checks++; if (muxData !== 32'hCAFE_F00D || RuWr_wb !== 1'b1) begin
      errors++; $display("FAIL st_ld_b2b: data=%h wr=%b want cafef00d/1", muxData, RuWr_wb); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, d; logic [4:0] r, rw; logic w, m, ww;
    exec_one(st(32'h40, 32'h0123_4567, 3'b010), a, r, w, m, d, rw, ww);
    @(negedge clk); drive(mk(32'h99, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0));
    @(negedge clk); drive(st(32'h40, 32'hFFFF_FFFF, 3'b010));
    @(posedge clk); #1;
    checks++; if (muxData !== 32'h99 || alu_out_me !== 32'h40) begin
      errors++; $display("FAIL pre_reset: data=%h alu=%h want 99/40", muxData, alu_out_me); end
    #1 rst_n = 1'b0; drive('0);
    #1;
    checks++; if (alu_out_me !== 32'h0 || rd_me !== 5'd0 || RuWr_me !== 1'b0 ||
                  muxData !== 32'h0 || rd_wb !== 5'd0 || RuWr_wb !== 1'b0) begin
      errors++; $display("FAIL async_reset: alu=%h rd=%0d wr=%b data=%h rdwb=%0d wrwb=%b want all 0",
                         alu_out_me, rd_me, RuWr_me, muxData, rd_wb, RuWr_wb); end
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    exec_one(ld(32'h40, 3'b010, 5'd3), a, r, w, m, d, rw, ww);
    checks++; if (d !== 32'h0123_4567) begin errors++; $display("FAIL reset_store_lost: got %h want 01234567", d); end
  endtask

  task automatic test_random();
    instr_t cur;
    logic [31:0] wd; logic [4:0] wrd; logic wwr, emis, wflush, have_wb;
    have_wb = 1'b0; wflush = 1'b0; wd = '0; wrd = '0; wwr = 1'b0;
    for (int k = 0; k < 16 + 300 + 1; k++) begin
      @(negedge clk);
      if (k < 16) cur = st(($urandom & 32'hFFFF_FC00) | 32'(k * 4), $urandom, 3'b010);
      else if (k < 316) cur = rand_instr();
      else cur = '0;
      drive(cur);
      @(posedge clk); #1;
      if (have_wb) begin
        checks++; if (RuWr_wb !== wwr) begin errors++; $display("FAIL rnd_wr_wb[%0d]: got %b want %b", k, RuWr_wb, wwr); end
        if (!wflush) begin
          checks++; if (muxData !== wd || rd_wb !== wrd) begin
            errors++; $display("FAIL rnd_wb[%0d]: data=%h rd=%0d want %h/%0d", k, muxData, rd_wb, wd, wrd); end
        end
      end
      model(cur, wd, wrd, wwr, emis);
      wflush = cur.flush;
      checks++; if (RuWr_me !== (cur.ruwr && !cur.flush)) begin
        errors++; $display("FAIL rnd_wr_me[%0d]: got %b want %b", k, RuWr_me, cur.ruwr && !cur.flush); end
      if (!cur.flush) begin
        checks++; if (alu_out_me !== cur.alu || rd_me !== cur.rd || misaligned_me !== emis) begin
          errors++; $display("FAIL rnd_me[%0d]: alu=%h rd=%0d mis=%b want %h/%0d/%b",
                             k, alu_out_me, rd_me, misaligned_me, cur.alu, cur.rd, emis); end
      end
      have_wb = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_sb_and_misaligned();
    test_jal_flush();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline, sitting between execute and write-back. Holds the EX/MEM and MEM/WB pipeline registers, performs byte/half/word loads and stores against a local data memory, and selects the write-back value. It is the producing end of the forwarding interface consumed by execute: `alu_out_me`, `rd_me`, `RuWr_me`, `muxData`, `rd_wb` and `RuWr_wb` all originate here.

## Interface
- `DEPTH`, 256, data memory depth in 32-bit words; power of two.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_out_ex`  in  32  execute ALU result: load/store byte address, or write-back value.
- `ru2_fwd_ex`  in  32  store data, already forwarded by execute.
- `pc_ex`  in  32  PC of the instruction in execute.
- `rd_ex`  in  5  destination register.
- `RuWr_ex`  in  1  register-file write enable.
- `DMWr_ex`  in  1  data-memory write enable.
- `DMCtrl_ex`  in  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- `RuDataWrSrc_ex`  in  2  write-back source: 00 ALU, 01 memory, 10 PC+4.
- `flush_ex`  in  1  turn the instruction entering EX/MEM into a bubble.
- `alu_out_me`  out  32  EX/MEM ALU result (forwarding source).
- `rd_me`  out  5  EX/MEM destination register.
- `RuWr_me`  out  1  EX/MEM register write enable.
- `muxData`  out  32  MEM/WB selected write-back data.
- `rd_wb`  out  5  MEM/WB destination register.
- `RuWr_wb`  out  1  MEM/WB register write enable.
- `misaligned_me`  out  1  combinational: access in MEM is misaligned.

## Operation
- EX/MEM register captures all `_ex` inputs every cycle. `flush_ex`=1 captures `RuWr`=0 and `DMWr`=0; other fields are don't-care.
- Word index = `alu_out_me[log2(DEPTH)+1:2]`; upper address bits ignored (wrap modulo 4·DEPTH bytes).
- Misaligned: half access with `addr[0]`=1, or word access with `addr[1:0]`≠0. Byte access is never misaligned. Asserted only when the MEM instruction is a store, or a load (`RuDataWrSrc`=01).
- Store, aligned, `DMWr`=1: byte lanes enabled by size and `addr[1:0]`; data taken from the low byte/half of `ru2` and replicated into the selected lane. Other lanes are unchanged.
- Store, misaligned: no memory write.
- Load: the word is read combinationally in MEM. The lane selected by `addr[1:0]` is extracted, then sign- or zero-extended per `DMCtrl`.
- Load, misaligned: result 0, and `RuWr` into MEM/WB is forced to 0.
- Write-back mux, registered into MEM/WB as `muxData`: 00 selects `alu_out_me`, 01 selects the load result, 10 selects `pc_me`+4 (32-bit, wraps). Code 11 yields 0.
- `rd_wb`/`RuWr_wb` follow from EX/MEM; forced to 0 on misaligned load.
- Encodings 011, 110 and 111 of `DMCtrl` are treated as word.

## Timing
- Instruction in EX during cycle n: its EX/MEM outputs are valid in cycle n+1; its store commits at the end of n+1; `muxData`, `rd_wb` and `RuWr_wb` are valid in cycle n+2.
- Store then load to the same word in consecutive instructions: the load, in MEM at n+2, sees the stored data (write at end of n+1).
- Reset, asynchronous and active-low: every pipeline register output goes to 0, including `alu_out_me`, `rd_me`, `RuWr_me`, `muxData`, `rd_wb` and `RuWr_wb`. Internal `DMWr` goes to 0, so no store is issued while `rst_n`=0 or in the first cycle after release. Memory contents are not reset.
- Reset asserted mid-store: the store is lost. Memory is not corrupted.
- `flush_ex` is sampled at the same edge as the `_ex` inputs. A flushed instruction produces no store and no register write two cycles later.
- `rd`=0 is passed through unchanged; suppressing writes to x0 is the register file's job.

## Structure
- Shared package `riscv_pkg`: `DMCtrl` encodings, `RuDataWrSrc` encodings, and EX/MEM and MEM/WB packed struct typedefs.
- Sub-module `data_mem`:
  - parameter `DEPTH`;
  - ports `clk`, `addr`, `wdata`, 4-bit byte enable `be`, `we`, `rdata`;
  - synchronous write, combinational read, no reset.
- `mem_stage` contains both pipeline registers, lane/extension logic and the write-back mux.

## Test plan
- SW `0xDEADBEEF` to address 0x10, then LW 0x10 → `muxData`=0xDEADBEEF two cycles after the load is in EX; `RuWr_wb`=1.
- After that store, LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB `0x000000AA` to 0x11 over word 0xDEADBEEF → LW 0x10 returns 0xDEADAAEF.
- SW to 0x12: `misaligned_me`=1 and memory is unchanged. LH 0x11: `RuWr_wb`=0 and `muxData`=0.
- JAL in EX with `pc_ex`=0x100, `RuDataWrSrc`=10, `rd`=1 → `muxData`=0x104 and `rd_wb`=1. The same instruction with `flush_ex`=1 → `RuWr_me`=0, `RuWr_wb`=0.
- Forwarding and reset:
  - ALU instruction with result 0x55 in EX at cycle n → in n+1, `alu_out_me`=0x55 and `RuWr_me`=1.
  - Drop `rst_n` mid-cycle → all outputs 0 immediately, without a clock edge.
